// File: rtl/mc_control_v2_if.sv
// rtl/mc_control_v2_if.sv - control-unit to datapath/memory signal bundle
interface mc_control_v2_if #(
    parameter int ALUCTRL_W = 6
);
    logic [5:0]           op;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic [1:0]           pc_src;
    logic                 ir_write;
    logic                 iord;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic                 zero_ext;
    logic [ALUCTRL_W-1:0] alu_control;
    logic                 instr_done;
    logic                 illegal;
    logic                 mem_timeout;
    logic [3:0]           state;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               zero_ext, alu_control, instr_done, illegal, mem_timeout, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_write, pc_src, ir_write, iord, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               zero_ext, alu_control, instr_done, illegal, mem_timeout, state
    );
endinterface

// File: rtl/mc_control_v2.sv
// rtl/mc_control_v2.sv - multicycle MIPS control FSM with memory wait states and watchdog
module mc_control_v2 #(
    parameter int ALUCTRL_W = 6,
    parameter int MAX_WAIT  = 16,
    parameter int WAIT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    mc_control_v2_if.master  bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMM_EX  = 4'd9,
        S_IMM_WB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(6'b100000);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(6'b100010);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(6'b100100);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(6'b100101);

    localparam bit                WD_EN     = (MAX_WAIT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              illegal_q;
    logic              timeout_q;
    logic              wait_state;
    logic              timeout_now;
    logic              strobe_en;
    logic              pc_write_r, ir_write_r, mem_read_r, mem_write_r, reg_write_r, instr_done_r;

    assign wait_state  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout_now = WD_EN && wait_state && !bus.mem_ready && (wait_cnt == WAIT_LAST);
    assign strobe_en   = !rst && !timeout_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Counter only survives a stall cycle, so any entry into a wait state sees zero
            if (wait_state && !bus.mem_ready && !timeout_now)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (state == S_ILLEGAL)
                illegal_q <= 1'b1;
            if (timeout_now)
                timeout_q <= 1'b1;

            case (state)
                S_FETCH: begin
                    if (timeout_now)        state <= S_FETCH;
                    else if (bus.mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW:              state <= S_MEMADR;
                        OP_RTYPE:                  state <= S_EXEC_R;
                        OP_BEQ, OP_BNE:            state <= S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI:  state <= S_IMM_EX;
                        OP_J:                      state <= S_JUMP;
                        default:                   state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: state <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (timeout_now)        state <= S_FETCH;
                    else if (bus.mem_ready) state <= S_MEMWB;
                end
                S_MEMWR: begin
                    if (timeout_now || bus.mem_ready) state <= S_FETCH;
                end
                S_EXEC_R: state <= S_ALU_WB;
                S_IMM_EX: state <= S_IMM_WB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write_r      = 1'b0;
        ir_write_r      = 1'b0;
        mem_read_r      = 1'b0;
        mem_write_r     = 1'b0;
        reg_write_r     = 1'b0;
        instr_done_r    = 1'b0;
        bus.pc_src      = 2'b00;
        bus.iord        = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.zero_ext    = 1'b0;
        bus.alu_control = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_read_r    = 1'b1;
                bus.alu_src_b = 2'b01;
                ir_write_r    = bus.mem_ready;
                pc_write_r    = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = 2'b11;
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read_r = 1'b1;
                bus.iord   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_r    = 1'b1;
                bus.mem_to_reg = 1'b1;
                instr_done_r   = 1'b1;
            end
            S_MEMWR: begin
                mem_write_r  = 1'b1;
                bus.iord     = 1'b1;
                instr_done_r = bus.mem_ready;
            end
            S_EXEC_R: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALUCTRL_W'(bus.funct);
            end
            S_ALU_WB: begin
                reg_write_r  = 1'b1;
                bus.reg_dst  = 1'b1;
                instr_done_r = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = ALU_SUB;
                bus.pc_src      = 2'b01;
                instr_done_r    = 1'b1;
                pc_write_r      = (bus.op == OP_BNE) ? !bus.zero : bus.zero;
            end
            // Write-back keeps the execute-phase ALU setup so ALUOut stays consistent
            S_IMM_EX, S_IMM_WB: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                if (bus.op == OP_ANDI) begin
                    bus.alu_control = ALU_AND;
                    bus.zero_ext    = 1'b1;
                end else if (bus.op == OP_ORI) begin
                    bus.alu_control = ALU_OR;
                    bus.zero_ext    = 1'b1;
                end
                if (state == S_IMM_WB) begin
                    reg_write_r  = 1'b1;
                    instr_done_r = 1'b1;
                end
            end
            S_JUMP: begin
                bus.pc_src   = 2'b10;
                pc_write_r   = 1'b1;
                instr_done_r = 1'b1;
            end
            S_ILLEGAL: instr_done_r = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_write    = pc_write_r   && strobe_en;
    assign bus.ir_write    = ir_write_r   && strobe_en;
    assign bus.mem_read    = mem_read_r   && strobe_en;
    assign bus.mem_write   = mem_write_r  && strobe_en;
    assign bus.reg_write   = reg_write_r  && strobe_en;
    assign bus.instr_done  = instr_done_r && strobe_en;
    assign bus.illegal     = illegal_q || (state == S_ILLEGAL);
    assign bus.mem_timeout = timeout_q || (timeout_now && !rst);
    assign bus.state       = state;
endmodule

// File: tb/tb_mc_control_v2.sv
// tb/tb_mc_control_v2.sv - directed self-checking bench for mc_control_v2
module tb_mc_control_v2;
    localparam int MW = 4;
    localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BAD = 6'b111111;
    localparam logic [5:0] A_ADD = 6'b100000, A_SUB = 6'b100010, A_AND = 6'b100100, A_OR = 6'b100101;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [5:0] alu_control;
        logic       instr_done, illegal, mem_timeout;
    } outs_t;

    typedef struct {
        logic [5:0] op, funct;
        logic       zero, mr;
        outs_t      e;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_control_v2_if #(.ALUCTRL_W(6)) bus ();
    mc_control_v2 #(.ALUCTRL_W(6), .MAX_WAIT(MW), .WAIT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0, n_bad = 0, cyc = 0, last_cpi = 0;
    rec_t q[$];
    rec_t cur;
    bit   cur_valid = 0;
    bit   m_ill = 0, m_to = 0;
    logic mr_idle = 1'b1;
    logic [5:0] c_op, c_funct;
    logic c_zero;

    function automatic outs_t sample();
        outs_t a;
        a.state = bus.state; a.pc_write = bus.pc_write; a.pc_src = bus.pc_src;
        a.ir_write = bus.ir_write; a.iord = bus.iord; a.mem_read = bus.mem_read;
        a.mem_write = bus.mem_write; a.reg_write = bus.reg_write; a.reg_dst = bus.reg_dst;
        a.mem_to_reg = bus.mem_to_reg; a.alu_src_a = bus.alu_src_a; a.alu_src_b = bus.alu_src_b;
        a.zero_ext = bus.zero_ext; a.alu_control = bus.alu_control; a.instr_done = bus.instr_done;
        a.illegal = bus.illegal; a.mem_timeout = bus.mem_timeout;
        return a;
    endfunction

    always @(negedge clk) begin
        outs_t act;
        if (rst) cyc = 0;
        else if (bus.instr_done) begin last_cpi = cyc + 1; cyc = 0; end
        else cyc++;
        if (cur_valid && !rst) begin
            n_cmp++;
            act = sample();
            if (act !== cur.e) begin
                n_bad++;
                $display("FAIL cycle op=%b mr=%b: got %h want %h (state got %0d want %0d)",
                         cur.op, cur.mr, act, cur.e, act.state, cur.e.state);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic outs_t blank(input int st);
        outs_t o = '0;
        o.state = 4'(st);
        o.alu_control = A_ADD;
        o.illegal = m_ill;
        o.mem_timeout = m_to;
        return o;
    endfunction

    task automatic push(input outs_t e, input logic mr);
        rec_t r;
        r.op = c_op; r.funct = c_funct; r.zero = c_zero; r.mr = mr; r.e = e;
        q.push_back(r);
    endtask

    task automatic play();
        while (q.size() > 0) begin
            cur = q.pop_front();
            bus.op = cur.op; bus.funct = cur.funct; bus.zero = cur.zero; bus.mem_ready = cur.mr;
            cur_valid = 1;
            @(posedge clk); #1;
        end
        cur_valid = 0;
    endtask

    task automatic fetch_decode(input int waits);
        outs_t o;
        for (int i = 0; i < waits; i++) begin
            o = blank(0); o.mem_read = 1; o.alu_src_b = 2'b01; push(o, 1'b0);
        end
        o = blank(0); o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = 1; o.pc_write = 1; push(o, 1'b1);
        o = blank(1); o.alu_src_b = 2'b11; push(o, mr_idle);
    endtask

    task automatic memadr();
        outs_t o = blank(2);
        o.alu_src_a = 1; o.alu_src_b = 2'b10; push(o, mr_idle);
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                         input int fw, input int mw);
        outs_t o;
        c_op = op; c_funct = funct; c_zero = zero;
        fetch_decode(fw);
        case (op)
            LW: begin
                memadr();
                for (int i = 0; i <= mw; i++) begin
                    o = blank(3); o.mem_read = 1; o.iord = 1; push(o, (i == mw));
                end
                o = blank(4); o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; push(o, mr_idle);
            end
            SW: begin
                memadr();
                for (int i = 0; i <= mw; i++) begin
                    o = blank(5); o.mem_write = 1; o.iord = 1; o.instr_done = (i == mw); push(o, (i == mw));
                end
            end
            RT: begin
                o = blank(6); o.alu_src_a = 1; o.alu_control = funct; push(o, mr_idle);
                o = blank(7); o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; push(o, mr_idle);
            end
            BEQ, BNE: begin
                o = blank(8); o.alu_src_a = 1; o.alu_control = A_SUB; o.pc_src = 2'b01; o.instr_done = 1;
                o.pc_write = (op == BEQ) ? zero : !zero; push(o, mr_idle);
            end
            ADDI, ANDI, ORI: begin
                o = blank(9); o.alu_src_a = 1; o.alu_src_b = 2'b10;
                o.alu_control = (op == ANDI) ? A_AND : (op == ORI) ? A_OR : A_ADD;
                o.zero_ext = (op != ADDI); push(o, mr_idle);
                o.state = 4'd10; o.reg_write = 1; o.instr_done = 1; push(o, mr_idle);
            end
            J: begin
                o = blank(11); o.pc_src = 2'b10; o.pc_write = 1; o.instr_done = 1; push(o, mr_idle);
            end
            default: begin
                m_ill = 1;
                o = blank(12); o.instr_done = 1; push(o, mr_idle);
            end
        endcase
        play();
    endtask

    task automatic fetch_timeout();
        outs_t o;
        c_op = RT; c_funct = A_ADD; c_zero = 0;
        for (int i = 0; i < MW - 1; i++) begin
            o = blank(0); o.mem_read = 1; o.alu_src_b = 2'b01; push(o, 1'b0);
        end
        m_to = 1;
        o = blank(0); o.alu_src_b = 2'b01; push(o, 1'b0);
        play();
    endtask

    task automatic sw_stall(input int stalls, input bit do_timeout);
        outs_t o;
        c_op = SW; c_funct = 6'd0; c_zero = 0;
        fetch_decode(0);
        memadr();
        for (int i = 0; i < stalls; i++) begin
            o = blank(5); o.mem_write = 1; o.iord = 1; push(o, 1'b0);
        end
        if (do_timeout) begin
            m_to = 1;
            o = blank(5); o.iord = 1; push(o, 1'b0);
        end
        play();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 0; bus.mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_strobes", {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write, bus.instr_done}, 0);
        chk("rst_flags", {bus.illegal, bus.mem_timeout}, 0);
        rst = 0;

        mr_idle = 1'b1;
        instr(RT, A_ADD, 0, 0, 0);  chk("cpi_add", last_cpi, 4);
        instr(RT, A_SUB, 1, 0, 0);
        instr(LW, 6'd0, 0, 0, 0);   chk("cpi_lw", last_cpi, 5);
        instr(LW, 6'd0, 0, 1, 3);   chk("cpi_lw_waits", last_cpi, 9);
        instr(SW, 6'd0, 0, 0, 0);   chk("cpi_sw", last_cpi, 4);
        instr(BEQ, 6'd0, 1, 0, 0);  chk("cpi_beq", last_cpi, 3);
        instr(BEQ, 6'd0, 0, 0, 0);
        instr(BNE, 6'd0, 1, 0, 0);
        instr(BNE, 6'd0, 0, 0, 0);
        instr(ADDI, 6'd0, 0, 0, 0);
        instr(ANDI, 6'd0, 0, 0, 0);
        instr(ORI, 6'd0, 0, 0, 0);  chk("cpi_ori", last_cpi, 4);
        instr(J, 6'd0, 0, 0, 0);    chk("cpi_j", last_cpi, 3);

        mr_idle = 1'b0;
        instr(BAD, 6'd0, 0, 0, 0);  chk("cpi_illegal", last_cpi, 3);
        chk("illegal_sticky", bus.illegal, 1);
        instr(RT, A_OR, 0, 2, 0);
        fetch_timeout();
        chk("fetch_retry_state", bus.state, 0);
        instr(RT, A_AND, 0, 0, 0);
        sw_stall(MW - 1, 1);
        chk("sw_timeout_state", bus.state, 0);
        chk("timeout_sticky", bus.mem_timeout, 1);
        instr(ORI, 6'd0, 0, 0, 0);

        sw_stall(2, 0);
        #1;
        chk("pre_rst_mem_write", bus.mem_write, 1);
        rst = 1;
        #1;
        chk("mid_rst_state", bus.state, 0);
        chk("mid_rst_mem_write", bus.mem_write, 0);
        chk("mid_rst_flags", {bus.illegal, bus.mem_timeout}, 0);
        m_ill = 0; m_to = 0;
        @(posedge clk); #1;
        rst = 0;
        instr(RT, A_ADD, 0, 0, 0);  chk("cpi_after_rst", last_cpi, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_control_v2.md
Name: mc_control_v2

Overview:
- Parametrised multicycle MIPS control unit for the multicycle datapath.
- Generalised successor to the current five-opcode controller. Adds:
  - BNE, ANDI, ORI and J;
  - a mem_ready wait-state handshake on every memory access, with a configurable timeout watchdog;
  - illegal-opcode detection;
  - an instruction-retire pulse.
- Drives all datapath mux selects and write strobes. The PC, IR, A/B, ALUOut and Data registers stay in the datapath.

Parameters:
- ALUCTRL_W, 6, alu_control width; must be ≥ 6; funct and internal codes are zero-extended to this width.
- MAX_WAIT, 16, max cycles waiting for mem_ready before timeout; 0 disables the watchdog.
- WAIT_W, 5, wait-counter width; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag, combinational from the current ALU operation
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],instr[25:0],2'b00}
- ir_write  out  1  IR load enable
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 rt, 1 rd
- mem_to_reg  out  1  0 ALUOut, 1 Data
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- zero_ext  out  1  immediate is zero-extended (ANDI/ORI)
- alu_control  out  ALUCTRL_W  ADD 100000, SUB 100010, AND 100100, OR 100101, or funct
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  sticky, unrecognised opcode seen
- mem_timeout  out  1  sticky, watchdog expired
- state  out  4  current state, for debug

Behaviour:
- Opcodes:
  - LW 100011, SW 101011, R-type 000000, BEQ 000100, BNE 000101
  - ADDI 001000, ANDI 001100, ORI 001101, J 000010
- Outputs:
  - Moore decode of the state register, plus mem_ready/zero gating where noted.
  - Unlisted strobes are 0. Unlisted selects are 0 and alu_control is ADD.
- Reset (rst=1, asynchronous):
  - state=FETCH, wait counter=0, illegal=0, mem_timeout=0.
  - All strobes (pc_write, ir_write, mem_read, mem_write, reg_write, instr_done) forced 0 while rst=1.
  - Reset mid-instruction abandons it; no partial writes follow.
- States and transitions:
  - FETCH (0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
    - When mem_ready=1: ir_write=1, pc_write=1, next DECODE.
    - Otherwise stay.
  - DECODE (1): alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by op:
    - LW/SW → MEMADR; R-type → EXEC_R; BEQ/BNE → BRANCH
    - ADDI/ANDI/ORI → IMM_EX; J → JUMP; any other op → ILLEGAL
  - MEMADR (2): alu_src_a=1, alu_src_b=10, ADD. Next MEMRD for LW, MEMWR for SW.
  - MEMRD (3): mem_read=1, iord=1. Next MEMWB on mem_ready, else stay.
  - MEMWB (4): reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next FETCH.
  - MEMWR (5): mem_write=1, iord=1.
    - On mem_ready: instr_done=1, next FETCH. Else stay.
  - EXEC_R (6): alu_src_a=1, alu_src_b=00, alu_control=funct. Next ALU_WB.
  - ALU_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next FETCH.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, SUB, pc_src=01, instr_done=1, next FETCH.
    - pc_write = zero for BEQ, ~zero for BNE.
  - IMM_EX (9): alu_src_a=1, alu_src_b=10.
    - ADD for ADDI; AND with zero_ext=1 for ANDI; OR with zero_ext=1 for ORI.
    - Next IMM_WB.
  - IMM_WB (10): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next FETCH.
    - alu_control, alu_src_a/b and zero_ext hold their IMM_EX values.
  - JUMP (11): pc_src=10, pc_write=1, instr_done=1. Next FETCH.
  - ILLEGAL (12): sets illegal=1, instr_done=1, no writes. Next FETCH.
  - Codes 13–15: next FETCH, no outputs asserted.
- Watchdog (only when MAX_WAIT>0; active in FETCH, MEMRD, MEMWR):
  - Counter is cleared on entering these states.
  - Counter increments each cycle with mem_ready=0.
  - If mem_ready=0 when counter==MAX_WAIT−1:
    - mem_timeout←1 and all strobes are suppressed that cycle;
    - next state is FETCH with counter cleared;
    - a timeout in FETCH retries the fetch.
  - mem_ready=1 on that same cycle takes priority: normal completion, no timeout.
- mem_ready is ignored in all other states.
- Zero-wait memory (mem_ready tied 1) gives these CPIs: LW 5, SW 4, R-type 4, ADDI/ANDI/ORI 4, BEQ/BNE 3, J 3.
- illegal and mem_timeout clear only on rst.

Test Plan:
- mem_ready=1; ADD (op 000000, funct 100000) → states 0,1,6,7; EXEC_R alu_control=100000; ALU_WB reg_write=1, reg_dst=1, instr_done=1; 4 cycles.
- LW with mem_ready low 3 cycles in MEMRD → state 3 held 4 cycles, mem_read=1, iord=1 throughout; then MEMWB reg_write=1, mem_to_reg=1.
- BEQ with zero=1 → BRANCH pc_write=1, pc_src=01, alu_control=100010; BNE with zero=1 → pc_write=0; both return to FETCH.
- ORI → IMM_EX alu_control=100101, zero_ext=1, alu_src_b=10; J → pc_write=1, pc_src=10; op 111111 → illegal=1 after ILLEGAL, next FETCH.
- MAX_WAIT=4, mem_ready=0 in MEMWR → mem_timeout=1 on 4th wait cycle, mem_write dropped that cycle, state→0.
- Assert rst during MEMWR → state=0 immediately, mem_write=0, illegal/mem_timeout=0; release → fetch resumes.
